// File: rtl/piradip_trigger_stream_gate.sv
// piradip_trigger_stream_gate: arms on a selected trigger edge, skips `delay` beats, then forwards `length` beats.
module piradip_trigger_stream_gate #(
  parameter int DATA_WIDTH  = 128,
  parameter int SEL_WIDTH   = 5,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2**SEL_WIDTH-1:0]  triggers,
  input  logic [SEL_WIDTH-1:0]     trig_sel,
  input  logic [COUNT_WIDTH-1:0]   delay,
  input  logic [COUNT_WIDTH-1:0]   length,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     busy,
  output logic                     done,
  output logic                     missed
);
  typedef enum logic [1:0] {IDLE, ARMED, DELAY, CAPTURE} state_t;
  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);
  state_t state_q, state_d;
  logic [2**SEL_WIDTH-1:0] trig_q;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [COUNT_WIDTH-1:0] delay_q, delay_d, length_q, length_d, dcnt_q, dcnt_d, ccnt_q, ccnt_d;
  logic done_q, done_d, missed_q, missed_d;
  logic trig_edge, beat, cap;
  assign trig_edge = triggers[sel_q] & ~trig_q[sel_q];
  assign cap = state_q == CAPTURE;
  // Outside CAPTURE the upstream is always accepted so beats are dropped, never stalled.
  assign s_axis_tready = cap ? m_axis_tready : 1'b1;
  assign m_axis_tvalid = cap & s_axis_tvalid;
  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tlast = cap & (ccnt_q == ONE);
  assign beat = s_axis_tvalid & s_axis_tready;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign missed = missed_q;
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    delay_d = delay_q;
    length_d = length_q;
    dcnt_d = dcnt_q;
    ccnt_d = ccnt_q;
    done_d = 1'b0;
    missed_d = missed_q | (trig_edge & (state_q == DELAY || state_q == CAPTURE));
    if (abort) state_d = IDLE;
    else case (state_q)
      IDLE: if (arm) begin
        sel_d = trig_sel;
        delay_d = delay;
        length_d = length;
        missed_d = 1'b0;
        state_d = ARMED;
      end
      ARMED: if (trig_edge) begin
        if (delay_q != '0) begin
          dcnt_d = delay_q;
          state_d = DELAY;
        end else if (length_q != '0) begin
          ccnt_d = length_q;
          state_d = CAPTURE;
        end else begin
          done_d = 1'b1;
          state_d = IDLE;
        end
      end
      DELAY: if (beat) begin
        dcnt_d = dcnt_q - ONE;
        if (dcnt_q == ONE) begin
          if (length_q != '0) begin
            ccnt_d = length_q;
            state_d = CAPTURE;
          end else begin
            done_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      CAPTURE: if (beat) begin
        ccnt_d = ccnt_q - ONE;
        if (ccnt_q == ONE) begin
          done_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      trig_q <= '0;
      sel_q <= '0;
      delay_q <= '0;
      length_q <= '0;
      dcnt_q <= '0;
      ccnt_q <= '0;
      done_q <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q <= triggers;
      sel_q <= sel_d;
      delay_q <= delay_d;
      length_q <= length_d;
      dcnt_q <= dcnt_d;
      ccnt_q <= ccnt_d;
      done_q <= done_d;
      missed_q <= missed_d;
    end
  end
endmodule

// File: tb/tb_piradip_trigger_stream_gate.sv
// tb_piradip_trigger_stream_gate: scoreboard bench; expected beats are queued when the trigger fires.
module tb_piradip_trigger_stream_gate;
  localparam int DW = 128, SW = 5, CW = 32;
  logic clk = 1'b0, rst;
  logic [2**SW-1:0] triggers;
  logic [SW-1:0] trig_sel;
  logic [CW-1:0] delay, length;
  logic arm, abort;
  logic [DW-1:0] s_axis_tdata, m_axis_tdata;
  logic s_axis_tvalid, s_axis_tready, m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic busy, done, missed;
  int n_chk, n_pass, done_cnt, last_cnt, n;
  bit bp;
  logic [DW:0] sbq[$];

  piradip_trigger_stream_gate #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .triggers(triggers), .trig_sel(trig_sel), .delay(delay), .length(length),
    .arm(arm), .abort(abort), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done), .missed(missed)
  );

  always #5 clk = ~clk;

  // One clock: monitor at negedge, then advance the source after the rising edge.
  task automatic tick();
    logic beat;
    logic [DW:0] exp;
    @(negedge clk);
    beat = s_axis_tvalid & s_axis_tready;
    if (done) done_cnt++;
    if (m_axis_tvalid && m_axis_tready) begin
      n_chk++;
      if (m_axis_tlast) last_cnt++;
      if (sbq.size() == 0) $display("FAIL unexpected_beat got data=%0h last=%0b required no beat", m_axis_tdata, m_axis_tlast);
      else begin
        exp = sbq.pop_front();
        if ({m_axis_tlast, m_axis_tdata} !== exp)
          $display("FAIL beat got last=%0b data=%0h required last=%0b data=%0h", m_axis_tlast, m_axis_tdata, exp[DW], exp[DW-1:0]);
        else n_pass++;
      end
    end
    if (m_axis_tvalid) begin
      n_chk++;
      if (s_axis_tready !== m_axis_tready) $display("FAIL ready_mirror got %0b required %0b", s_axis_tready, m_axis_tready);
      else n_pass++;
    end
    @(posedge clk);
    #1;
    if (beat) begin
      n++;
      s_axis_tdata = DW'(n);
    end
    if (bp) m_axis_tready = ~m_axis_tready;
  endtask

  task automatic do_arm(input int sel, input int d, input int l);
    trig_sel = SW'(sel);
    delay = CW'(d);
    length = CW'(l);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trig_sel = SW'($urandom);
    delay = $urandom;
    length = $urandom;
    done_cnt = 0;
    last_cnt = 0;
    n_chk++;
    if (busy !== 1'b1) $display("FAIL arm_busy got %0b required 1", busy);
    else n_pass++;
  endtask

  task automatic fire(input int sel, input int d, input int l);
    triggers[sel] = 1'b1;
    for (int i = 1; i <= l; i++) sbq.push_back({i == l, DW'(n + d + i)});
    tick();
    triggers[sel] = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (sbq.size() > 0 && b < 200) begin
      tick();
      b++;
    end
    n_chk++;
    if (sbq.size() != 0) $display("FAIL drain_timeout got %0d pending required 0", sbq.size());
    else n_pass++;
    sbq.delete();
    tick();
    tick();
  endtask

  task automatic test_end(input string name, input int exp_done, input int exp_last);
    n_chk++;
    if (done_cnt !== exp_done) $display("FAIL %s_done got %0d required %0d", name, done_cnt, exp_done);
    else n_pass++;
    n_chk++;
    if (last_cnt !== exp_last) $display("FAIL %s_tlast got %0d required %0d", name, last_cnt, exp_last);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL %s_busy got %0b required 0", name, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_chk++;
    if ({busy, done, missed, m_axis_tvalid, s_axis_tready} !== 5'b00001)
      $display("FAIL reset_outputs got %b required 00001", {busy, done, missed, m_axis_tvalid, s_axis_tready});
    else n_pass++;
  endtask

  task automatic test_basic();
    do_arm(3, 0, 4);
    tick();
    fire(3, 0, 4);
    drain();
    test_end("basic", 1, 1);
  endtask

  task automatic test_delay();
    do_arm(7, 5, 3);
    tick();
    tick();
    fire(7, 5, 3);
    drain();
    test_end("delay", 1, 1);
  endtask

  task automatic test_backpressure();
    bp = 1'b1;
    do_arm(0, 0, 8);
    fire(0, 0, 8);
    drain();
    bp = 1'b0;
    m_axis_tready = 1'b1;
    test_end("backpressure", 1, 1);
  endtask

  task automatic test_level_edge();
    triggers[2] = 1'b1;
    do_arm(2, 0, 6);
    n_chk++;
    if (missed !== 1'b0) $display("FAIL arm_clears_missed got %0b required 0", missed);
    else n_pass++;
    repeat (3) tick();
    n_chk++;
    if (busy !== 1'b1) $display("FAIL level_no_trigger got busy=%0b required 1", busy);
    else n_pass++;
    triggers[2] = 1'b0;
    tick();
    fire(2, 0, 6);
    tick();
    triggers[2] = 1'b1;
    tick();
    triggers[2] = 1'b0;
    drain();
    n_chk++;
    if (missed !== 1'b1) $display("FAIL missed_set got %0b required 1", missed);
    else n_pass++;
    test_end("level", 1, 1);
  endtask

  task automatic test_zero_length();
    do_arm(5, 0, 0);
    fire(5, 0, 0);
    drain();
    test_end("zero_len", 1, 0);
  endtask

  task automatic test_abort();
    abort = 1'b1;
    arm = 1'b1;
    tick();
    abort = 1'b0;
    arm = 1'b0;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL abort_over_arm got busy=%0b required 0", busy);
    else n_pass++;
    do_arm(1, 0, 6);
    fire(1, 0, 6);
    tick();
    tick();
    s_axis_tvalid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    s_axis_tvalid = 1'b1;
    sbq.delete();
    tick();
    tick();
    m_axis_tready = 1'b0;
    #1;
    n_chk++;
    if (s_axis_tready !== 1'b1) $display("FAIL abort_tready got %0b required 1", s_axis_tready);
    else n_pass++;
    m_axis_tready = 1'b1;
    test_end("abort", 0, 0);
  endtask

  task automatic test_reset_mid_capture();
    do_arm(9, 0, 10);
    fire(9, 0, 10);
    tick();
    triggers[9] = 1'b1;
    tick();
    triggers[9] = 1'b0;
    tick();
    n_chk++;
    if ({missed, m_axis_tvalid} !== 2'b11) $display("FAIL pre_reset got missed,tvalid=%b required 11", {missed, m_axis_tvalid});
    else n_pass++;
    m_axis_tready = 1'b0;
    #2 rst = 1'b1;
    #1;
    test_reset();
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_axis_tready = 1'b1;
    do_arm(4, 2, 3);
    fire(4, 2, 3);
    drain();
    test_end("post_reset", 1, 1);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    n = 0;
    bp = 1'b0;
    rst = 1'b1;
    triggers = '0;
    trig_sel = '0;
    delay = '0;
    length = '0;
    arm = 1'b0;
    abort = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    #3;
    test_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_basic();
    test_delay();
    test_backpressure();
    test_level_edge();
    test_zero_length();
    test_abort();
    test_reset_mid_capture();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
